gray_rank_filter_3x3: RTL
=========================

// Module: gray_rank_filter_3x3
// PURPOSE
//  Streaming 3x3 rank-order filter for DATA_W-bit grey video. Selectable per frame: median, min (erosion), max (dilation), bypass.
//  Successor to the fixed 8-bit median path: parametrised width, border replication, run-time mode.
//  Owns its two line buffers. Sits between the grey converter and the threshold/edge stages of the VIP chain.
// PARAMETERS
//  DATA_W      8    pixel width in bits (1..16)
//  IMG_HDISP   640  active pixels per line; line-buffer depth
//  IMG_VDISP   480  active lines per frame; row-counter bound
//  BORDER_MODE 1    0 = taps outside the image read 0; 1 = taps replicate the nearest in-image pixel
// PORTS
//  clk              in   1       sole clock, rising edge
//  rst              in   1       asynchronous, active-high reset
//  mode             in   2       0 median, 1 min, 2 max, 3 bypass; sampled at the pre_gray_vsync rising edge
//  pre_gray_vsync   in   1       frame sync, high for the whole frame
//  pre_gray_valid   in   1       line-active (href)
//  pre_gray_clken   in   1       pixel strobe; a sample is accepted when valid && clken
//  pre_gray_data    in   DATA_W  grey pixel
//  post_gray_vsync  out  1       pre_gray_vsync delayed by LAT
//  post_gray_valid  out  1       pre_gray_valid delayed by LAT
//  post_gray_clken  out  1       pre_gray_clken delayed by LAT
//  post_pixel_data  out  DATA_W  filtered pixel; forced to 0 when post_gray_valid = 0
// BEHAVIOUR
//  - Reset: all outputs 0; counters 0; active mode = 0 (median). Line-buffer RAM contents are not reset.
//    Reset mid-frame discards the frame. Output resumes correctly from the next vsync rising edge.
//  - Counters: col counts 0..IMG_HDISP-1 and increments per accepted sample. col clears on the falling edge of valid.
//    row increments on each valid falling edge, saturating at IMG_VDISP-1. Both clear on the vsync rising edge.
//  - Line buffers: two DATA_W x IMG_HDISP RAMs form a cascade (row r-1, row r-2), read/written at address col.
//    They advance only on accepted samples.
//  - Window: the input row supplies taps p31..p33, row r-1 supplies p21..p23, row r-2 supplies p11..p13.
//    Columns are c-2, c-1, c. The result is written at the input position, so the image is shifted by (+1,+1), as in the existing median path.
//  - Border, row side: row 0 has no r-1/r-2 taps; row 1 has no r-2 taps.
//    BORDER_MODE 1 substitutes the nearest existing row; BORDER_MODE 0 substitutes 0.
//  - Border, column side: col 0 and col 1 lack the c-2/c-1 taps and are handled the same way, substituting column c.
//  - Rank: the sort network is a 3-stage pipeline: row-sort, column max/med/min, final med/min/max.
//    Stage registers advance every clk. Sorting is unsigned and compares all DATA_W bits; no overflow is possible.
//  - Mode 3 outputs tap p22 unchanged. min/max use the same network outputs as median.
//  - Latency LAT = 4 clk from the accepted input to post_pixel_data: 1 window register + 3 sort stages.
//    The three sync outputs use a matching 4-deep shift register, so data and strobes stay aligned for any clken duty cycle.
//  - mode changes are applied only at the vsync rising edge, so a frame never mixes modes.
//    If vsync rises in the same cycle as an accepted sample, counters clear first and that sample is col 0 of row 0.
//  - Lines longer than IMG_HDISP: col holds at IMG_HDISP-1 and extra samples overwrite the last RAM address.
//    Short lines: the remaining RAM entries keep stale data and are only read for columns that are never accepted.
// STRUCTURE
//  - Package vip_pkg: mode localparams (MODE_MEDIAN=0, MODE_MIN=1, MODE_MAX=2, MODE_BYPASS=3),
//    BORDER_ZERO/BORDER_REPL, and LAT=4.
//  - Sub-module sort3_u (DATA_W param): registered 3-input max/med/min, instantiated 7 times by the network.
//  - Top level holds the counters, line RAMs, border muxes and sync delay line.
// TESTING
//  1 Flat frame: 8x6 image of all 0x55, every mode -> every valid output = 0x55; vsync/valid/clken = input delayed 4 clk.
//  2 Impulse: single 0xFF at (3,3) in zeros, median -> all outputs 0. max -> 0xFF over the 3x3 block at outputs (3..5,3..5).
//  3 Border: row 0 = ramp 1..8, BORDER_MODE 1, min.
//    -> output (0,0)=1, (0,1)=1, (0,2)=1, (0,3)=2. Same stimulus with BORDER_MODE 0 -> outputs 0.
//  4 clken gaps: random 50% clken on a ramp frame -> outputs bit-identical to the clken=1 run; latency is always 4 clk.
//  5 Mode switch: mode changed mid-frame 0->2 -> no effect until the next vsync rise, then max applies from pixel (0,0).
//  6 Reset mid-line (rst for 3 clk at row 2, col 5) -> outputs 0 during reset; next frame matches the golden model. DATA_W=12 regression of scenarios 1-2.

Source files
------------

// File: rtl/gray_rank_filter_3x3_pkg.sv
// Shared constants and types for the 3x3 grey rank-order filter.
package vip_pkg;

  localparam logic [1:0] MODE_MEDIAN = 2'd0;
  localparam logic [1:0] MODE_MIN    = 2'd1;
  localparam logic [1:0] MODE_MAX    = 2'd2;
  localparam logic [1:0] MODE_BYPASS = 2'd3;

  localparam int unsigned BORDER_ZERO = 0;
  localparam int unsigned BORDER_REPL = 1;

  localparam int unsigned LAT = 4;

  typedef struct packed {
    logic vsync;
    logic valid;
    logic clken;
  } sync_t;

endpackage

// File: rtl/gray_rank_filter_3x3_if.sv
// Grey video stream: frame sync, line-active, pixel strobe and pixel data.
interface gray_rank_filter_3x3_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              vsync;
  logic              valid;
  logic              clken;
  logic [DATA_W-1:0] data;

  modport master (output vsync, output valid, output clken, output data);
  modport slave  (input  vsync, input  valid, input  clken, input  data);
endinterface

// File: rtl/gray_rank_filter_3x3_sort3_u.sv
// Registered unsigned 3-input sorter: largest, middle and smallest value.
module sort3_u #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] mid,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] ab_hi, ab_lo;
  logic [DATA_W-1:0] hi_c, mid_c, lo_c;

  always_comb begin
    ab_hi = (a > b) ? a : b;
    ab_lo = (a > b) ? b : a;
    hi_c  = (c > ab_hi) ? c : ab_hi;
    lo_c  = (c < ab_lo) ? c : ab_lo;
    if (c > ab_hi)      mid_c = ab_hi;
    else if (c < ab_lo) mid_c = ab_lo;
    else                mid_c = c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi  <= '0;
      mid <= '0;
      lo  <= '0;
    end else begin
      hi  <= hi_c;
      mid <= mid_c;
      lo  <= lo_c;
    end
  end

endmodule

// File: rtl/gray_rank_filter_3x3.sv
// Streaming 3x3 median/min/max/bypass filter with two internal line buffers.
// Output is aligned to the input position (image shifted by +1,+1).
module gray_rank_filter_3x3
  import vip_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned IMG_HDISP   = 640,
  parameter int unsigned IMG_VDISP   = 480,
  parameter int unsigned BORDER_MODE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  gray_rank_filter_3x3_if.slave         pre_gray,
  gray_rank_filter_3x3_if.master        post_gray
);

  localparam int unsigned COL_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int unsigned ROW_W = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_HDISP - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_VDISP - 1);
  localparam bit REPL = (BORDER_MODE == BORDER_REPL);

  logic              vsync_d, valid_d;
  logic              vs_rise, valid_fall, acc;
  logic [COL_W-1:0]  col, col_cur, col_next;
  logic [ROW_W-1:0]  row, row_cur;
  logic [1:0]        active_mode, mode_cur;
  logic [1:0]        mode_s1, mode_s2, mode_s3;

  logic [DATA_W-1:0] ram1 [IMG_HDISP];
  logic [DATA_W-1:0] ram2 [IMG_HDISP];
  logic [DATA_W-1:0] rd1, rd2;
  logic [DATA_W-1:0] nc  [3];
  logic [DATA_W-1:0] win [3][3];
  logic [DATA_W-1:0] p22_s2, p22_s3;

  sync_t             sd [LAT];

  assign vs_rise    = pre_gray.vsync & ~vsync_d;
  assign valid_fall = valid_d & ~pre_gray.valid;
  assign acc        = pre_gray.valid & pre_gray.clken;
  assign col_cur    = vs_rise ? '0 : col;
  assign row_cur    = vs_rise ? '0 : row;
  assign col_next   = (col_cur == COL_MAX) ? col_cur : col_cur + COL_W'(1);
  assign mode_cur   = vs_rise ? mode : active_mode;

  // Position counters; a sample coinciding with the vsync rise is (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d     <= 1'b0;
      valid_d     <= 1'b0;
      col         <= '0;
      row         <= '0;
      active_mode <= MODE_MEDIAN;
    end else begin
      vsync_d <= pre_gray.vsync;
      valid_d <= pre_gray.valid;
      if (vs_rise) begin
        active_mode <= mode;
        row         <= '0;
        col         <= acc ? col_next : '0;
      end else if (valid_fall) begin
        col <= '0;
        row <= (row == ROW_MAX) ? row : row + ROW_W'(1);
      end else if (acc) begin
        col <= col_next;
      end
    end
  end

  // Line-buffer cascade: ram1 holds row r-1, ram2 holds row r-2.
  always_ff @(posedge clk) begin
    if (acc) begin
      ram1[col_cur] <= pre_gray.data;
      ram2[col_cur] <= ram1[col_cur];
    end
  end

  assign rd1 = ram1[col_cur];
  assign rd2 = ram2[col_cur];

  // New window column with row-side border substitution (nc[0] = row r-2).
  always_comb begin
    nc[2] = pre_gray.data;
    nc[1] = REPL ? pre_gray.data : '0;
    if (row_cur != '0) nc[1] = rd1;
    nc[0] = REPL ? nc[1] : '0;
    if (row_cur > ROW_W'(1)) nc[0] = rd2;
  end

  // Window shift; missing left columns take column c or zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else if (acc) begin
      for (int i = 0; i < 3; i++) begin
        win[i][2] <= nc[i];
        if (col_cur == '0) begin
          win[i][0] <= REPL ? nc[i] : '0;
          win[i][1] <= REPL ? nc[i] : '0;
        end else if (col_cur == COL_W'(1)) begin
          win[i][0] <= REPL ? nc[i] : '0;
          win[i][1] <= win[i][2];
        end else begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_s1 <= MODE_MEDIAN;
      mode_s2 <= MODE_MEDIAN;
      mode_s3 <= MODE_MEDIAN;
      p22_s2  <= '0;
      p22_s3  <= '0;
      for (int i = 0; i < int'(LAT); i++) sd[i] <= '0;
    end else begin
      mode_s1 <= mode_cur;
      mode_s2 <= mode_s1;
      mode_s3 <= mode_s2;
      p22_s2  <= win[1][1];
      p22_s3  <= p22_s2;
      sd[0]   <= {pre_gray.vsync, pre_gray.valid, pre_gray.clken};
      for (int i = 1; i < int'(LAT); i++) sd[i] <= sd[i-1];
    end
  end

  logic [DATA_W-1:0] r_hi [3];
  logic [DATA_W-1:0] r_mid [3];
  logic [DATA_W-1:0] r_lo [3];

  for (genvar i = 0; i < 3; i++) begin : g_row
    sort3_u #(.DATA_W(DATA_W)) u_row (
      .clk (clk), .rst (rst),
      .a   (win[i][0]), .b (win[i][1]), .c (win[i][2]),
      .hi  (r_hi[i]), .mid (r_mid[i]), .lo (r_lo[i])
    );
  end

  logic [DATA_W-1:0] g_max, g_min, min_of_max, med_of_med, max_of_min;
  logic [DATA_W-1:0] unused_ch_mid, unused_cm_hi, unused_cm_lo, unused_cl_mid;
  logic [DATA_W-1:0] unused_fin_hi, unused_fin_lo;
  logic [DATA_W-1:0] fa, fb, fc, fin_mid;

  sort3_u #(.DATA_W(DATA_W)) u_col_hi (
    .clk (clk), .rst (rst), .a (r_hi[0]), .b (r_hi[1]), .c (r_hi[2]),
    .hi (g_max), .mid (unused_ch_mid), .lo (min_of_max)
  );
  sort3_u #(.DATA_W(DATA_W)) u_col_mid (
    .clk (clk), .rst (rst), .a (r_mid[0]), .b (r_mid[1]), .c (r_mid[2]),
    .hi (unused_cm_hi), .mid (med_of_med), .lo (unused_cm_lo)
  );
  sort3_u #(.DATA_W(DATA_W)) u_col_lo (
    .clk (clk), .rst (rst), .a (r_lo[0]), .b (r_lo[1]), .c (r_lo[2]),
    .hi (max_of_min), .mid (unused_cl_mid), .lo (g_min)
  );

  // Final stage: mode and line-blanking select what the last sorter sees.
  always_comb begin
    fa = min_of_max;
    fb = med_of_med;
    fc = max_of_min;
    case (mode_s3)
      MODE_MEDIAN: ;
      MODE_MIN:    begin fa = g_min;  fb = g_min;  fc = g_min;  end
      MODE_MAX:    begin fa = g_max;  fb = g_max;  fc = g_max;  end
      MODE_BYPASS: begin fa = p22_s3; fb = p22_s3; fc = p22_s3; end
      default: ;
    endcase
    if (!sd[LAT-2].valid) begin
      fa = '0;
      fb = '0;
      fc = '0;
    end
  end

  sort3_u #(.DATA_W(DATA_W)) u_fin (
    .clk (clk), .rst (rst), .a (fa), .b (fb), .c (fc),
    .hi (unused_fin_hi), .mid (fin_mid), .lo (unused_fin_lo)
  );

  assign post_gray.vsync = sd[LAT-1].vsync;
  assign post_gray.valid = sd[LAT-1].valid;
  assign post_gray.clken = sd[LAT-1].clken;
  assign post_gray.data  = fin_mid;

endmodule
